// File: rtl/spu_tile_sequencer_pkg.sv
// spu_tile_sequencer_pkg: colour, sprite command and sequencer state types shared by the tile sequencer.
package spu_tile_sequencer_pkg;
  typedef logic [23:0] ColorRGB;
  typedef logic [31:0] ColorRGBA;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    ColorRGBA    color;
    logic        last;
  } SpriteCmd;
  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, READ} SeqState;
endpackage

// File: rtl/spu_tile_sequencer_cmd_fifo.sv
// spu_cmd_fifo: SpriteCmd FIFO with full/empty/count; a push while full is taken only together with a pop.
module spu_cmd_fifo
  import spu_tile_sequencer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  SpriteCmd                 din,
  input  logic                     pop,
  output SpriteCmd                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  SpriteCmd mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = count[AW];
  assign empty   = count == '0;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/spu_tile_sequencer.sv
// spu_tile_sequencer: clear / per-sprite draw / read-out sweeps of the SPU for one tile job.
// Define SPU_SEQ_CULL_EN to pop sprites whose origin lies at or past the tile's far edge in one cycle.
module spu_tile_sequencer
  import spu_tile_sequencer_pkg::*;
#(
  parameter  int TILE_SIZE = 10,
  parameter  int CMD_DEPTH = 8,
  localparam int PW        = $clog2(TILE_SIZE)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [9:0]    i_tile_x,
  input  logic [9:0]    i_tile_y,
  input  logic [23:0]   i_clear_color,
  input  logic          i_no_sprites,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [15:0]   i_cmd_sprite_x,
  input  logic [15:0]   i_cmd_sprite_y,
  input  logic [31:0]   i_cmd_color,
  input  logic          i_cmd_last,
  output logic          o_spu_enable,
  output logic          o_spu_clear,
  output logic          o_spu_draw_sprite,
  output logic          o_spu_get_color,
  output logic [9:0]    o_spu_tile_x,
  output logic [9:0]    o_spu_tile_y,
  output logic [PW-1:0] o_spu_process_x,
  output logic [PW-1:0] o_spu_process_y,
  output logic [23:0]   o_spu_clear_color,
  output logic [15:0]   o_spu_sprite_x,
  output logic [15:0]   o_spu_sprite_y,
  output logic [31:0]   o_spu_sprite_color,
  input  logic [23:0]   i_spu_color,
  output logic          o_pix_valid,
  input  logic          i_pix_ready,
  output logic [23:0]   o_pix_color,
  output logic [PW-1:0] o_pix_x,
  output logic [PW-1:0] o_pix_y,
  output logic          o_pix_last,
  output logic          o_busy,
  output logic          o_done
);
  localparam logic [PW-1:0] LAST_POS = PW'(TILE_SIZE - 1);
  SeqState state, state_nx;
  SpriteCmd head, cmd_in;
  logic [PW-1:0] px, py;
  logic [$clog2(CMD_DEPTH):0] count;
  logic no_sprites, rd_done, full, empty, pop, draw, show, issue, accept, adv, at_end, culled;
  assign cmd_in = '{x: i_cmd_sprite_x, y: i_cmd_sprite_y, color: i_cmd_color, last: i_cmd_last};
  spu_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk   (i_clock),
    .rst   (i_reset),
    .push  (i_cmd_valid && !full),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
`ifdef SPU_SEQ_CULL_EN
  logic [15:0] edge_x, edge_y;
  assign edge_x = 16'(o_spu_tile_x) * 16'(TILE_SIZE) + 16'(TILE_SIZE - 1);
  assign edge_y = 16'(o_spu_tile_y) * 16'(TILE_SIZE) + 16'(TILE_SIZE - 1);
  assign culled = head.x >= edge_x || head.y >= edge_y;
`else
  assign culled = 1'b0;
`endif
  assign at_end = px == LAST_POS && py == LAST_POS;
  assign show   = state == DRAW && !empty;
  assign draw   = show && !culled;
  assign pop    = show && (culled || at_end);
  assign accept = o_pix_valid && i_pix_ready;
  // Issue a read only when the output register is free or being drained this cycle.
  assign issue  = state == READ && !rd_done && (!o_pix_valid || i_pix_ready);
  assign adv    = state == CLEAR || draw || issue;
  assign o_cmd_ready        = !full;
  assign o_busy             = state != IDLE;
  assign o_done             = accept && o_pix_last;
  assign o_pix_color        = o_pix_valid ? i_spu_color : '0;
  assign o_spu_process_x    = px;
  assign o_spu_process_y    = py;
  assign o_spu_sprite_x     = show ? head.x : '0;
  assign o_spu_sprite_y     = show ? head.y : '0;
  assign o_spu_sprite_color = show ? head.color : '0;
  always_comb begin
    state_nx          = state;
    o_spu_enable      = 1'b0;
    o_spu_clear       = 1'b0;
    o_spu_draw_sprite = 1'b0;
    o_spu_get_color   = 1'b0;
    case (state)
      IDLE:  state_nx = i_start ? CLEAR : IDLE;
      CLEAR: begin
        o_spu_enable = 1'b1;
        o_spu_clear  = 1'b1;
        state_nx     = at_end ? (no_sprites ? READ : DRAW) : CLEAR;
      end
      DRAW: begin
        o_spu_enable      = draw;
        o_spu_draw_sprite = draw;
        state_nx          = pop && head.last ? READ : DRAW;
      end
      READ: begin
        o_spu_enable    = issue;
        o_spu_get_color = issue;
        state_nx        = o_done ? IDLE : READ;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state             <= IDLE;
      px                <= '0;
      py                <= '0;
      o_spu_tile_x      <= '0;
      o_spu_tile_y      <= '0;
      o_spu_clear_color <= '0;
      no_sprites        <= 1'b0;
      rd_done           <= 1'b0;
      o_pix_valid       <= 1'b0;
      o_pix_x           <= '0;
      o_pix_y           <= '0;
      o_pix_last        <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && i_start) begin
        o_spu_tile_x      <= i_tile_x;
        o_spu_tile_y      <= i_tile_y;
        o_spu_clear_color <= i_clear_color;
        no_sprites        <= i_no_sprites;
        rd_done           <= 1'b0;
      end
      if (adv) begin
        px <= px == LAST_POS ? '0 : px + PW'(1);
        if (px == LAST_POS) py <= py == LAST_POS ? '0 : py + PW'(1);
      end
      if (issue) begin
        o_pix_x    <= px;
        o_pix_y    <= py;
        o_pix_last <= at_end;
        rd_done    <= at_end;
      end
      o_pix_valid <= issue || (o_pix_valid && !i_pix_ready);
    end
  end
  always_ff @(posedge i_clock) if (!i_reset) assert (empty == (count == '0));
endmodule

// File: tb/tb_spu_tile_sequencer.sv
// tb_spu_tile_sequencer: tile jobs against a behavioural SPU and a per-pixel expected-image model.
`timescale 1ns/1ps
module tb_spu_tile_sequencer;
  localparam int TS = 10;
  localparam int PW = $clog2(TS);
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic i_reset, i_start, i_no_sprites, i_cmd_valid, i_cmd_last, i_pix_ready;
  logic [9:0] i_tile_x, i_tile_y;
  logic [23:0] i_clear_color, i_spu_color;
  logic [15:0] i_cmd_sprite_x, i_cmd_sprite_y;
  logic [31:0] i_cmd_color;
  logic o_cmd_ready, o_spu_enable, o_spu_clear, o_spu_draw_sprite, o_spu_get_color;
  logic [9:0] o_spu_tile_x, o_spu_tile_y;
  logic [PW-1:0] o_spu_process_x, o_spu_process_y, o_pix_x, o_pix_y;
  logic [23:0] o_spu_clear_color, o_pix_color;
  logic [15:0] o_spu_sprite_x, o_spu_sprite_y;
  logic [31:0] o_spu_sprite_color;
  logic o_pix_valid, o_pix_last, o_busy, o_done;

  spu_tile_sequencer #(.TILE_SIZE(TS), .CMD_DEPTH(8)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start),
    .i_tile_x(i_tile_x), .i_tile_y(i_tile_y), .i_clear_color(i_clear_color), .i_no_sprites(i_no_sprites),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_sprite_x(i_cmd_sprite_x), .i_cmd_sprite_y(i_cmd_sprite_y), .i_cmd_color(i_cmd_color), .i_cmd_last(i_cmd_last),
    .o_spu_enable(o_spu_enable), .o_spu_clear(o_spu_clear), .o_spu_draw_sprite(o_spu_draw_sprite),
    .o_spu_get_color(o_spu_get_color), .o_spu_tile_x(o_spu_tile_x), .o_spu_tile_y(o_spu_tile_y),
    .o_spu_process_x(o_spu_process_x), .o_spu_process_y(o_spu_process_y), .o_spu_clear_color(o_spu_clear_color),
    .o_spu_sprite_x(o_spu_sprite_x), .o_spu_sprite_y(o_spu_sprite_y), .o_spu_sprite_color(o_spu_sprite_color),
    .i_spu_color(i_spu_color), .o_pix_valid(o_pix_valid), .i_pix_ready(i_pix_ready),
    .o_pix_color(o_pix_color), .o_pix_x(o_pix_x), .o_pix_y(o_pix_y), .o_pix_last(o_pix_last),
    .o_busy(o_busy), .o_done(o_done)
  );

  // Premultiplied "over": src + dst * (255 - a) / 255 per channel, saturating.
  function automatic logic [23:0] blend(logic [23:0] dst, logic [31:0] src);
    logic [23:0] r;
    int a, v;
    a = int'(src[31:24]);
    for (int c = 0; c < 3; c++) begin
      v = int'(src[c*8 +: 8]) + int'(dst[c*8 +: 8]) * (255 - a) / 255;
      r[c*8 +: 8] = v > 255 ? 8'hFF : 8'(v);
    end
    return r;
  endfunction

  // A sprite covers global pixels strictly beyond its origin on both axes.
  function automatic bit covers(logic [9:0] t, int p, logic [15:0] s);
    logic [15:0] g;
    g = 16'(t) * 16'(TS) + 16'(p);
    return g > s;
  endfunction

  logic [23:0] mem [TS][TS];
  always @(posedge clk) begin
    if (o_spu_enable) begin
      if (o_spu_clear)
        mem[o_spu_process_y][o_spu_process_x] <= o_spu_clear_color;
      else if (o_spu_draw_sprite && covers(o_spu_tile_x, int'(o_spu_process_x), o_spu_sprite_x)
               && covers(o_spu_tile_y, int'(o_spu_process_y), o_spu_sprite_y))
        mem[o_spu_process_y][o_spu_process_x] <= blend(mem[o_spu_process_y][o_spu_process_x], o_spu_sprite_color);
      if (o_spu_get_color) i_spu_color <= mem[o_spu_process_y][o_spu_process_x];
    end
  end

  int clear_cyc = 0, draw_cyc = 0;
  always @(posedge clk) begin
    if (o_spu_enable && o_spu_clear) clear_cyc <= clear_cyc + 1;
    if (o_spu_enable && o_spu_draw_sprite) draw_cyc <= draw_cyc + 1;
  end

  int tests = 0, fails = 0;
  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [9:0] j_tx, j_ty;
  logic [23:0] j_clr;
  int j_n, j_stall, j_mode;
  logic [15:0] j_sx [4], j_sy [4];
  logic [31:0] j_sc [4];
  logic [23:0] exp_img [TS][TS], got_img [TS][TS];

  function automatic bit is_culled(int s);
`ifdef SPU_SEQ_CULL_EN
    return j_sx[s] >= 16'(j_tx) * 16'(TS) + 16'(TS - 1) || j_sy[s] >= 16'(j_ty) * 16'(TS) + 16'(TS - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic build_model();
    logic [23:0] c;
    for (int y = 0; y < TS; y++)
      for (int x = 0; x < TS; x++) begin
        c = j_clr;
        for (int s = 0; s < j_n; s++)
          if (covers(j_tx, x, j_sx[s]) && covers(j_ty, y, j_sy[s])) c = blend(c, j_sc[s]);
        exp_img[y][x] = c;
      end
  endtask

  task automatic push(logic [15:0] sx, logic [15:0] sy, logic [31:0] sc, logic last);
    i_cmd_sprite_x = sx;
    i_cmd_sprite_y = sy;
    i_cmd_color = sc;
    i_cmd_last = last;
    i_cmd_valid = 1'b1;
    for (int t = 0; t < 2000 && !o_cmd_ready; t++) @(negedge clk);
    if (!o_cmd_ready) check("cmd_ready_wait", o_cmd_ready, 1);
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic run_job();
    int c0, d0, nd, idx, errs, ord_err, stab_err, dones, exp_draw;
    logic pv, lr;
    logic [PW-1:0] lx, ly;
    logic [23:0] lc;
    build_model();
    c0 = clear_cyc; d0 = draw_cyc;
    idx = 0; errs = 0; ord_err = 0; stab_err = 0; dones = 0; exp_draw = 0;
    pv = 1'b0; lr = 1'b0; lx = '0; ly = '0; lc = '0;
    for (int s = 0; s < j_n; s++) if (!is_culled(s)) exp_draw += TS * TS;
    nd = (j_stall > 0 && j_n > 1) ? j_n - 1 : j_n;
    for (int s = 0; s < nd; s++) push(j_sx[s], j_sy[s], j_sc[s], s == j_n - 1);
    i_tile_x = j_tx; i_tile_y = j_ty; i_clear_color = j_clr; i_no_sprites = j_n == 0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    fork
      begin
        if (nd < j_n) begin
          int wf, se;
          wf = 0; se = 0;
          for (int s = 0; s < nd; s++) if (!is_culled(s)) wf += TS * TS;
          for (int t = 0; t < 5000 && draw_cyc - d0 < wf; t++) @(negedge clk);
          check("stall_reached", draw_cyc - d0, wf);
          for (int t = 0; t < j_stall; t++) begin
            if (o_spu_enable || o_spu_draw_sprite || o_spu_process_x != '0 || o_spu_process_y != '0) se++;
            @(negedge clk);
          end
          check("stall_idle", se, 0);
          push(j_sx[j_n-1], j_sy[j_n-1], j_sc[j_n-1], 1'b1);
        end
      end
      begin
        for (int t = 0; t < 8000 && idx < TS * TS; t++) begin
          i_pix_ready = j_mode == 0 ? 1'b1 : j_mode == 1 ? t[0] : 1'($urandom_range(0, 1));
          #1;
          if (pv && !lr && (!o_pix_valid || o_pix_x != lx || o_pix_y != ly || o_pix_color != lc)) stab_err++;
          if (o_done) dones++;
          if (o_pix_valid && i_pix_ready) begin
            if (o_pix_x != PW'(idx % TS) || o_pix_y != PW'(idx / TS) || o_pix_last != (idx == TS * TS - 1)) ord_err++;
            if (o_pix_color != exp_img[idx/TS][idx%TS]) errs++;
            got_img[idx/TS][idx%TS] = o_pix_color;
            idx++;
          end
          pv = o_pix_valid; lr = i_pix_ready; lx = o_pix_x; ly = o_pix_y; lc = o_pix_color;
          @(negedge clk);
        end
      end
    join
    check("clear_cycles", clear_cyc - c0, TS * TS);
    check("draw_cycles", draw_cyc - d0, exp_draw);
    check("pix_count", idx, TS * TS);
    check("pix_order", ord_err, 0);
    check("pix_color", errs, 0);
    check("pix_hold", stab_err, 0);
    check("done_pulses", dones, 1);
    check("busy_after", o_busy, 0);
  endtask

  typedef struct {
    logic [9:0] tx, ty;
    logic [23:0] clr;
    int n;
    logic [15:0] sx0, sy0;
    logic [31:0] sc0;
    logic [15:0] sx1, sy1;
    logic [31:0] sc1;
    int stall, mode;
    logic [23:0] e00, e99;
  } vec_t;
  vec_t vt [5];

  function automatic logic [63:0] all_outputs();
    return 64'(|{o_spu_enable, o_spu_clear, o_spu_draw_sprite, o_spu_get_color, o_spu_tile_x, o_spu_tile_y,
                 o_spu_process_x, o_spu_process_y, o_spu_clear_color, o_spu_sprite_x, o_spu_sprite_y,
                 o_spu_sprite_color, o_pix_valid, o_pix_color, o_pix_x, o_pix_y, o_pix_last, o_busy, o_done});
  endfunction

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_no_sprites = 1'b0; i_cmd_valid = 1'b0; i_cmd_last = 1'b0;
    i_pix_ready = 1'b0; i_tile_x = '0; i_tile_y = '0; i_clear_color = '0;
    i_cmd_sprite_x = '0; i_cmd_sprite_y = '0; i_cmd_color = '0;
    vt[0] = '{10'd0, 10'd0, 24'h102030, 0, 16'd0, 16'd0, 32'h0, 16'd0, 16'd0, 32'h0, 0, 0, 24'h102030, 24'h102030};
    vt[1] = '{10'd1, 10'd1, 24'h000000, 1, 16'd14, 16'd14, 32'h80FF0000, 16'd0, 16'd0, 32'h0, 0, 0, 24'h000000, 24'hFF0000};
    vt[2] = '{10'd1, 10'd1, 24'h000000, 2, 16'd14, 16'd14, 32'h80FF0000, 16'd100, 16'd100, 32'hFF00FF00, 20, 1, 24'h000000, 24'hFF0000};
    vt[3] = '{10'd0, 10'd0, 24'h0000FF, 1, 16'd100, 16'd0, 32'hFF123456, 16'd0, 16'd0, 32'h0, 0, 0, 24'h0000FF, 24'h0000FF};
    vt[4] = '{10'd2, 10'd0, 24'h404040, 2, 16'd15, 16'd0, 32'hFF000080, 16'd25, 16'd5, 32'h00101010, 0, 2, 24'h404040, 24'h101090};
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    #1;
    check("reset_outputs", all_outputs(), 0);
    check("reset_cmd_ready", o_cmd_ready, 1);
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      j_tx = vt[v].tx; j_ty = vt[v].ty; j_clr = vt[v].clr; j_n = vt[v].n;
      j_sx[0] = vt[v].sx0; j_sy[0] = vt[v].sy0; j_sc[0] = vt[v].sc0;
      j_sx[1] = vt[v].sx1; j_sy[1] = vt[v].sy1; j_sc[1] = vt[v].sc1;
      j_stall = vt[v].stall; j_mode = vt[v].mode;
      run_job();
      check($sformatf("vec%0d_pix00", v), got_img[0][0], vt[v].e00);
      check($sformatf("vec%0d_pix99", v), got_img[TS-1][TS-1], vt[v].e99);
    end

    for (int r = 0; r < 4; r++) begin
      j_tx = 10'($urandom_range(0, 5)); j_ty = 10'($urandom_range(0, 5));
      j_clr = 24'($urandom); j_n = $urandom_range(0, 3); j_stall = 0; j_mode = $urandom_range(0, 2);
      for (int s = 0; s < 4; s++) begin
        j_sx[s] = 16'(int'(j_tx) * TS + int'($urandom_range(0, 16)) - 4);
        j_sy[s] = 16'(int'(j_ty) * TS + int'($urandom_range(0, 16)) - 4);
        j_sc[s] = $urandom;
      end
      run_job();
    end

    for (int k = 0; k < 8; k++) push(16'(k), 16'(k), 32'h01010101, 1'b0);
    #1;
    check("cmd_ready_full", o_cmd_ready, 0);
    i_tile_x = 10'd2; i_tile_y = 10'd3; i_clear_color = 24'hABCDEF; i_no_sprites = 1'b0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int t = 0; t < 500 && !o_spu_draw_sprite; t++) @(negedge clk);
    check("reach_draw", o_spu_draw_sprite, 1);
    i_tile_x = 10'd5; i_tile_y = 10'd5; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("start_ignored", {o_spu_tile_x, o_spu_tile_y}, {10'd2, 10'd3});
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    #1;
    check("mid_draw_reset_outputs", all_outputs(), 0);
    check("mid_draw_reset_cmd_ready", o_cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spu_tile_sequencer.md
Name: spu_tile_sequencer

Overview:
- Control stage directly upstream of the SPU tile processor. Drives the SPU's pixel-sweep interface for one tile job at a time, in three phases:
  - Clear the tile to a colour.
  - Apply a queued list of sprites, one full-tile sweep per sprite.
  - Stream the finished tile pixels out with valid/ready for framebuffer writeback.
- Buffers sprite commands in a small FIFO so the command producer can run ahead of the sweep.

Parameters:
- TILE_SIZE, 10, tile edge in pixels; must match the SPU instance.
- CMD_DEPTH, 8, sprite command FIFO depth; power of two, ≥2.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_start  in  1  start tile job; honoured only in IDLE
- i_tile_x, i_tile_y  in  10 each  tile coordinates, latched on start
- i_clear_color  in  24  ColorRGB, latched on start
- i_no_sprites  in  1  latched on start; job skips the DRAW phase
- i_cmd_valid / o_cmd_ready  in/out  1  sprite command handshake
- i_cmd_sprite_x, i_cmd_sprite_y  in  16 each  sprite origin
- i_cmd_color  in  32  ColorRGBA, alpha already applied
- i_cmd_last  in  1  last sprite of the current tile
- o_spu_enable, o_spu_clear, o_spu_draw_sprite, o_spu_get_color  out  1  SPU controls
- o_spu_tile_x, o_spu_tile_y  out  10  latched tile coordinates
- o_spu_process_x, o_spu_process_y  out  $clog2(TILE_SIZE)  sweep position
- o_spu_clear_color  out  24  latched clear colour
- o_spu_sprite_x, o_spu_sprite_y  out  16, o_spu_sprite_color  out  32  FIFO head
- i_spu_color  in  24  SPU o_color_data
- o_pix_valid / i_pix_ready  out/in  1  pixel stream handshake
- o_pix_color  out  24, o_pix_x / o_pix_y  out  $clog2(TILE_SIZE), o_pix_last  out  1
- o_busy  out  1  FSM not in IDLE
- o_done  out  1  one-cycle pulse when the last pixel is accepted

Behaviour:
- Reset: FSM→IDLE, FIFO flushed, all outputs 0. Reset mid-job abandons the job; SPU contents are undefined afterwards.
- Sweep order: x is the inner loop, y the outer loop, (0,0)→(TS-1,TS-1); TS² positions per sweep.
- FSM states: IDLE, CLEAR, DRAW, READ.
- IDLE:
  - i_start latches tile, clear colour and no_sprites, then goes to CLEAR.
  - i_start while o_busy is ignored.
- CLEAR:
  - o_spu_enable=1 and o_spu_clear=1 for TS² consecutive cycles.
  - Then goes to READ if no_sprites is set, otherwise to DRAW.
- DRAW:
  - Per FIFO head: o_spu_enable=1 and o_spu_draw_sprite=1 while sprite fields present the head, for TS² cycles; pop on the last position.
  - FIFO empty: enable and draw are 0 and the sweep counter holds until a command arrives.
  - Popped entry with last=1 goes to READ; otherwise the next head is taken in the following cycle.
- READ:
  - Issue o_spu_get_color (with enable) for the current position when !o_pix_valid || i_pix_ready, then advance the position.
  - The SPU output is registered. o_pix_valid rises the cycle after issue; o_pix_color = i_spu_color (the SPU holds the value while get_color is low). o_pix_x/y are delayed copies of the issue position.
  - Throughput is 1 pixel/cycle when ready is held high.
  - o_pix_last=1 on (TS-1,TS-1). Its acceptance pulses o_done and returns the FSM to IDLE.
  - o_spu_clear and o_spu_draw_sprite are 0 throughout READ.
- FIFO:
  - o_cmd_ready = !full, in every state including IDLE (prefetch of the next tile's commands is allowed).
  - Push and pop in the same cycle when full is legal; count is unchanged.
- Arithmetic: the tile-base computation tile*TILE_SIZE is done in 16 bits; overflow wraps mod 2^16, matching the SPU.

Optional Feature:
- SPU_SEQ_CULL_EN defined: in DRAW, a head with sprite_x ≥ tile_x*TS+TS-1 or sprite_y ≥ tile_y*TS+TS-1 draws nothing in the SPU. Such a head is popped in one cycle with o_spu_draw_sprite=0; the last flag still applies.
- Undefined: every sprite gets the full TS²-cycle sweep.

Decomposition:
- Shared types package (alongside ColorRGB/ColorRGBA):
  - SpriteCmd struct {x[16], y[16], color ColorRGBA, last}.
  - SeqState enum {IDLE, CLEAR, DRAW, READ}.
- Sub-module spu_cmd_fifo: parameterised SpriteCmd FIFO with full/empty/count.

Test Plan:
- Start, tile (0,0), clear 0x102030, no_sprites=1, ready=1 → 100 clear cycles, then 100 pixels all 0x102030, o_pix_last at (9,9), o_done 1 cycle; o_busy low after.
- Tile (1,1), one sprite x=y=14, color 0x80FF0000 (a=0x80), clear 0 → pixels with x>4 and y>4 are 0xFF0000; others 0.
- FIFO empty for 20 cycles mid-DRAW → draw/enable low; the sweep resumes at the same position; result identical to the no-stall run.
- i_pix_ready toggled 1/0 → no pixel duplicated or dropped; x/y sequence monotonic; o_pix_color stable while valid && !ready.
- Push 8 commands in IDLE → o_cmd_ready low on the 9th; i_reset during DRAW → IDLE, o_cmd_ready=1, all outputs 0.
- With SPU_SEQ_CULL_EN, sprite x=100 for tile (0,0) → popped in 1 cycle; DRAW length reduced by 99 cycles.
